// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer family.
package mux_pkg;

  localparam int MAX_CH = 16;

  typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

  // Index width that stays at least one bit wide for degenerate channel counts.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr (mod NUM_CH) wins.
module rr_arbiter import mux_pkg::*; #(
  parameter int NUM_CH = 4,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any
);

  localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] rot;
  logic [CH_W-1:0]   off;
  logic [CH_W:0]     sum;

  // Rotate so ptr lands on bit 0; a fixed priority search then gives the offset.
  assign rot = NUM_CH'({req, req} >> ptr);
  assign any = |req;

  always_comb begin
    off = '0;
    for (int k = NUM_CH-1; k >= 0; k--)
      if (rot[k]) off = CH_W'(k);
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_CH_W) sum = sum - NUM_CH_W;
  end

  assign grant_idx = sum[CH_W-1:0];
  assign grant     = any ? (NUM_CH'(1) << grant_idx) : '0;

endmodule

// File: rtl/rr_stream_mux.sv
// Registered N:1 valid/ready stream mux with round-robin channel selection.
// Define RR_STREAM_MUX_LOCK_EN to hold the grant across multi-beat packets (in_last/out_last).
module rr_stream_mux import mux_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
`ifdef RR_STREAM_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0][DATA_W-1:0] in_arr;
  logic [NUM_CH-1:0]             req, grant;
  logic [CH_W-1:0]               rr_ptr, grant_idx, next_ptr;
  logic                          any, pipe_ready, xfer;

  assign in_arr     = in_data;
  assign pipe_ready = !out_valid || out_ready;
  assign xfer       = rst_n && pipe_ready && any;
  assign in_ready   = xfer ? grant : '0;
  assign next_ptr   = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);

`ifdef RR_STREAM_MUX_LOCK_EN
  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]      state;
  logic [CH_W-1:0] lock_ch;

  // Inside a packet only the owning channel is visible to the arbiter.
  assign req = (state == ST_LOCKED) ? (in_valid & (NUM_CH'(1) << lock_ch)) : in_valid;
`else
  assign req = in_valid;
`endif

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
`ifdef RR_STREAM_MUX_LOCK_EN
      out_last  <= 1'b0;
      state     <= ST_ARB;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_arr[grant_idx];
      out_ch    <= grant_idx;
`ifdef RR_STREAM_MUX_LOCK_EN
      out_last  <= in_last[grant_idx];
      if (in_last[grant_idx]) begin
        state  <= ST_ARB;
        rr_ptr <= next_ptr;
      end else begin
        state   <= ST_LOCKED;
        lock_ch <= grant_idx;
      end
`else
      rr_ptr    <= next_ptr;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed plus randomized bench for rr_stream_mux against a queue-free behavioural model.
module tb_rr_stream_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
`ifdef RR_STREAM_MUX_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef RR_STREAM_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // reference state: what the output register should hold and where the search starts
  bit         m_ov;
  logic [7:0] m_od;
  int         m_ch, m_ptr;
  bit         m_locked, m_ol;
  int         m_lock_ch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_od = '0; m_ch = 0; m_ptr = 0; m_locked = 0; m_ol = 0; m_lock_ch = 0;
  endtask

  function automatic void arb(output int g, output bit any);
    logic [N-1:0] elig;
    elig = in_valid;
    if (m_locked) elig = in_valid & (4'b0001 << m_lock_ch);
    g = 0; any = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (!any && elig[c]) begin g = c; any = 1; end
    end
  endfunction

  task automatic chk_out();
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    chk("out_data", {24'b0, out_data}, {24'b0, m_od});
    chk("out_ch", {30'b0, out_ch}, m_ch);
`ifdef RR_STREAM_MUX_LOCK_EN
    chk("out_last", {31'b0, out_last}, {31'b0, m_ol});
`endif
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    int g;
    bit any, pr;
    logic [N-1:0] er;
    logic [N-1:0][W-1:0] dv;
    arb(g, any);
    pr = !m_ov || out_ready;
    er = (pr && any) ? (4'b0001 << g) : 4'b0000;
    #1;
    chk("in_ready", {28'b0, in_ready}, {28'b0, er});
    dv = in_data;
    @(posedge clk); #1;
    if (pr && any) begin
      m_ov = 1; m_od = dv[g]; m_ch = g;
`ifdef RR_STREAM_MUX_LOCK_EN
      m_ol = in_last[g];
      if (in_last[g]) begin m_locked = 0; m_ptr = (g + 1) % N; end
      else begin m_locked = 1; m_lock_ch = g; end
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (out_ready) begin
      m_ov = 0;
    end
    chk_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int held;

  initial begin
    in_valid = '1; in_data = $urandom; out_ready = 1'b1;
`ifdef RR_STREAM_MUX_LOCK_EN
    in_last = '1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {28'b0, in_ready}, 32'h0);
    chk_out();
    rst_n = 1'b1;

    // all valid: strict rotation starting at channel 0, no bubbles
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      step();
      chk("rot_ch", {30'b0, out_ch}, i % 4);
      chk("rot_vld", {31'b0, out_valid}, 32'h1);
    end

    // backpressure holds the beat and blocks every input
    out_ready = 1'b0;
    held = int'(out_ch);
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      step();
      chk("bp_ch", {30'b0, out_ch}, held);
      chk("bp_ready", {28'b0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next", {30'b0, out_ch}, (held + 1) % 4);

    // single requester
    in_valid = 4'b0100; in_data = 32'h00A5_0000;
    step();
    chk("single_data", {24'b0, out_data}, 32'hA5);
    chk("single_ch", {30'b0, out_ch}, 2);
    in_valid = 4'b1111;
    step();
    chk("after_single", {30'b0, out_ch}, 3);

    // sparse wrap: move pointer to 1 then alternate 3,0,3
    in_valid = 4'b0001;
    step();
    in_valid = 4'b1001;
    step(); chk("sparse0", {30'b0, out_ch}, 3);
    step(); chk("sparse1", {30'b0, out_ch}, 0);
    step(); chk("sparse2", {30'b0, out_ch}, 3);

    // reset mid-stream drops the held beat at once
    in_valid = 4'b1111;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_ch", {30'b0, out_ch}, 32'h0);
    chk("mid_rst_ready", {28'b0, in_ready}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("rst_first_ch", {30'b0, out_ch}, 0);

    // random traffic
    repeat (300) begin
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_STREAM_MUX_LOCK_EN
      in_last   = N'($urandom);
`endif
      step();
    end

`ifdef RR_STREAM_MUX_LOCK_EN
    // packet lock: ch1 keeps the grant for three beats despite ch0/ch2 requests
    out_ready = 1'b1; in_last = '1; in_valid = '0;
    do_reset();
    in_valid = 4'b0001;
    step();
    in_valid = 4'b0111; in_last = 4'b1101;
    step(); chk("lock0", {30'b0, out_ch}, 1);
    step(); chk("lock1", {30'b0, out_ch}, 1);
    in_last = 4'b1111;
    step(); chk("lock2", {30'b0, out_ch}, 1);
    chk("lock_last", {31'b0, out_last}, 32'h1);
    step(); chk("lock_after", {30'b0, out_ch}, 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised, registered N:1 stream multiplexer; successor to the team's 4:1 combinational mux.
- Selection is by internal round-robin arbitration among requesting channels, not by external select lines.
- Valid/ready handshake on every input and on the output; one-stage output register.
- Sits between per-core result streams and the shared writeback/memory port of the mini-GPU.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 8, payload width per channel.
- CH_W, $clog2(NUM_CH), width of the channel-index output (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel request/valid.
- in_data  in  NUM_CH*DATA_W  packed payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel accept (combinational).
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered payload.
- out_ch  out  CH_W  index of the source channel of out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=0; in_ready=0 while rst_n=0.
- pipe_ready = !out_valid || out_ready (combinational).
- Arbitration: search in_valid starting at rr_ptr, wrapping modulo NUM_CH; the first set bit is grant g.
- in_ready[g] = pipe_ready && any(in_valid); all other in_ready bits are 0.
- in_ready never depends on in_valid of the same channel except through the grant.
- Transfer on input g when in_valid[g] && in_ready[g]. Next cycle: out_valid=1, out_data=in_data[g], out_ch=g, rr_ptr=(g+1) mod NUM_CH (wraps from NUM_CH-1 to 0).
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- If pipe_ready && no in_valid: out_valid clears (when out_ready=1); rr_ptr is unchanged.
- Backpressure: out_valid && !out_ready holds out_data/out_ch stable and drives in_ready all-0. rr_ptr is unchanged.
- Simultaneous out_ready consumption and new grant in the same cycle: the new beat replaces the old one, with no bubble.
- Fairness: with all channels continuously valid, grants rotate 0,1,2,...,NUM_CH-1,0.
- A channel with a pending request waits at most NUM_CH-1 grants.
- Reset mid-operation: the beat held in the output register is discarded; the arbiter restarts at channel 0.

Optional Feature:
- Macro: RR_STREAM_MUX_LOCK_EN.
- With the macro defined:
  - Adds port in_last (in, NUM_CH) and output out_last (registered alongside out_data).
  - Two-state FSM: ARB and LOCKED.
  - ARB -> LOCKED on a transfer with in_last[g]=0; the grant is frozen at g.
  - LOCKED: only channel g may transfer; other channels' requests are ignored.
  - LOCKED -> ARB on a transfer with in_last[g]=1; rr_ptr=(g+1) mod NUM_CH.
  - rr_ptr does not advance inside a packet.
- Without the macro: no in_last/out_last ports and no FSM; every beat is arbitrated independently.

Decomposition:
- Shared package mux_pkg:
  - function clog2_min1 (returns 1 for NUM_CH=1 guards);
  - localparam MAX_CH=16;
  - typedef ch_idx_t (sized to MAX_CH).
- Sub-module rr_arbiter (NUM_CH):
  - inputs: req, ptr;
  - outputs: grant one-hot, grant_idx, any.
- Top level holds the output register, rr_ptr and the lock FSM.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_ch=0, in_ready=4'b0000 immediately.
- Reset release: first grant goes to channel 0 when all channels are valid.
- Single requester: in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=2; next grant search starts at 3.
- All channels valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: out_ready=0 for 3 cycles with all valid -> out_data/out_ch stable, in_ready=0000.
- After release: the next out_ch is (held ch+1) mod 4.
- Sparse requests: in_valid=4'b1001 starting with rr_ptr=1 -> grant 3, then 0, then 3 (wrap-around check).
- LOCK_EN: ch1 sends 3 beats (in_last=0,0,1) while ch0/ch2 are valid -> out_ch=1,1,1, then 2.
